// File: rtl/ttc3_hmac_arbiter.sv
// Round-robin front end for a shared ttc3_hmac engine: grants one requester at a time,
// feeds the engine from ephemeral copies of the request, and scrubs them afterwards.
module ttc3_hmac_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*256-1:0] req_message,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [255:0]           rsp_tag,
  output logic                   rsp_error,
  output logic                   arb_busy,
  output logic                   hmac_start,
  output logic [255:0]           hmac_key,
  output logic [255:0]           hmac_message,
  input  logic                   hmac_done,
  input  logic                   hmac_busy,
  input  logic [255:0]           hmac_tag
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int IW1 = IW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [IW:0]         LP_NREQ     = IW1'(NUM_REQ);
  localparam logic [IW:0]         LP_IDX_ONE  = IW1'(1);
  localparam logic [TW-1:0]       LP_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]       LP_TMR_ONE  = TW'(1);
  localparam logic [NUM_REQ-1:0]  LP_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_idx;
  logic [255:0]    r_key_q;
  logic [255:0]    r_msg_q;
  logic [255:0]    r_tag_q;
  logic            r_err_q;
  logic [TW-1:0]   r_timer;

  logic            w_grant;
  logic            w_timeout;
  logic [IW-1:0]   w_win_idx;
  logic [255:0]    w_key_arr [NUM_REQ];
  logic [255:0]    w_msg_arr [NUM_REQ];

  // First requesting slot at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [IW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IW-1:0]      ptr);
    logic [2*NUM_REQ-1:0] rot;
    logic [IW:0]          sum;
    logic                 found;
    logic [IW-1:0]        pick;
    rot   = {req, req} >> ptr;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + IW1'(i);
      sum = (sum >= LP_NREQ) ? (sum - LP_NREQ) : sum;
      if (!found && rot[i]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] f_idx_inc(input logic [IW-1:0] idx);
    logic [IW:0] sum;
    sum = {1'b0, idx} + LP_IDX_ONE;
    sum = (sum >= LP_NREQ) ? (sum - LP_NREQ) : sum;
    return sum[IW-1:0];
  endfunction

  // Unpack the flat request buses into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_key_arr[i] = req_key[i*256 +: 256];
      w_msg_arr[i] = req_message[i*256 +: 256];
    end
  end

  // Gating on reset_n keeps req_ack low while reset is held, even with requests pending.
  assign w_grant   = (r_state == S_IDLE) && reset_n && (req_valid != '0) && !hmac_busy;
  assign w_win_idx = f_rr_pick(req_valid, r_rr_ptr);
  assign w_timeout = (r_timer == LP_TMO_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a done in the timeout cycle still counts as success.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (hmac_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ephemeral request/response copies, watchdog and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_key_q  <= '0;
      r_msg_q  <= '0;
      r_tag_q  <= '0;
      r_err_q  <= 1'b0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_idx   <= w_win_idx;
            r_key_q <= w_key_arr[w_win_idx];
            r_msg_q <= w_msg_arr[w_win_idx];
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= (r_timer == '1) ? r_timer : (r_timer + LP_TMR_ONE);
          if (hmac_done) begin
            r_tag_q <= hmac_tag;
            r_err_q <= 1'b0;
          end else if (w_timeout) begin
            r_tag_q <= '0;
            r_err_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_key_q  <= '0;
          r_msg_q  <= '0;
          r_tag_q  <= '0;
          r_err_q  <= 1'b0;
          r_rr_ptr <= f_idx_inc(r_idx);
        end
        default: begin
          r_timer <= r_timer;
        end
      endcase
    end
  end

  // Output decode: engine buses carry data only in ISSUE, the tag only in RESP.
  always_comb begin
    req_ack      = '0;
    rsp_valid    = '0;
    rsp_tag      = '0;
    rsp_error    = 1'b0;
    arb_busy     = 1'b0;
    hmac_start   = 1'b0;
    hmac_key     = '0;
    hmac_message = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ack = LP_ONE << w_win_idx;
        end else begin
          req_ack = '0;
        end
      end
      S_ISSUE: begin
        arb_busy     = 1'b1;
        hmac_start   = 1'b1;
        hmac_key     = r_key_q;
        hmac_message = r_msg_q;
      end
      S_WAIT: begin
        arb_busy = 1'b1;
      end
      S_RESP: begin
        arb_busy  = 1'b1;
        rsp_valid = LP_ONE << r_idx;
        rsp_error = r_err_q;
        if (r_err_q) begin
          rsp_tag = '0;
        end else begin
          rsp_tag = r_tag_q;
        end
      end
      S_CLEAR: begin
        arb_busy = 1'b1;
      end
      default: begin
        arb_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ttc3_hmac_arbiter.sv
// Scoreboard bench for ttc3_hmac_arbiter: stimulus queues expected grants and responses,
// a negedge monitor compares them, and a small engine model answers after a set delay.
module tb_ttc3_hmac_arbiter;

  localparam int N   = 4;
  localparam int TMO = 512;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N*256-1:0] req_key;
  logic [N*256-1:0] req_message;
  logic [N-1:0]     req_ack;
  logic [N-1:0]     rsp_valid;
  logic [255:0]     rsp_tag;
  logic             rsp_error;
  logic             arb_busy;
  logic             hmac_start;
  logic [255:0]     hmac_key;
  logic [255:0]     hmac_message;
  logic             hmac_done;
  logic             hmac_busy;
  logic [255:0]     hmac_tag;

  ttc3_hmac_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_key(req_key), .req_message(req_message),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
    .arb_busy(arb_busy), .hmac_start(hmac_start), .hmac_key(hmac_key),
    .hmac_message(hmac_message), .hmac_done(hmac_done), .hmac_busy(hmac_busy),
    .hmac_tag(hmac_tag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]   onehot;
    logic         err;
    logic [255:0] tag;
  } rsp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  rsp_t         sb_rsp[$];
  logic [3:0]   sb_ack[$];
  logic [255:0] keys [N];
  logic [255:0] msgs [N];
  int           eng_delay = 5;
  int           eng_cnt = 0;
  logic [255:0] eng_tag;
  int           start_cyc = 0;
  int           done_cyc = 0;
  int           ack_cyc = 0;
  int           zchk_cyc = -1;

  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_key[i*256 +: 256]     = keys[i];
      req_message[i*256 +: 256] = msgs[i];
    end
  end

  function automatic logic [255:0] f_tag(input logic [255:0] k, input logic [255:0] m);
    return k ^ {m[127:0], m[255:128]} ^ 256'h00c3_5a5a;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Engine model: done pulses eng_delay cycles after start; delay 0 means never.
  initial begin
    hmac_done = 1'b0;
    hmac_busy = 1'b0;
    hmac_tag  = '0;
    forever begin
      @(negedge clock);
      hmac_done = 1'b0;
      hmac_tag  = '0;
      if (!reset_n) begin
        eng_cnt   = 0;
        hmac_busy = 1'b0;
      end else if (hmac_start) begin
        eng_tag   = f_tag(hmac_key, hmac_message);
        eng_cnt   = eng_delay;
        start_cyc = cyc;
        hmac_busy = (eng_delay > 0);
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          hmac_done = 1'b1;
          hmac_tag  = eng_tag;
          hmac_busy = 1'b0;
          done_cyc  = cyc;
        end
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents an ack or a response.
  initial begin
    rsp_t e;
    logic [3:0] a;
    int exp_cyc;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (!hmac_start) chk("engine_bus_zero", hmac_key | hmac_message, 256'h0);
        if (rsp_valid == 4'b0000) chk("tag_idle_zero", {255'h0, rsp_error} | rsp_tag, 256'h0);
        if (req_ack != 4'b0000) begin
          if (sb_ack.size() == 0) begin
            chk("ack_unexpected", 256'(req_ack), 256'h0);
          end else begin
            a = sb_ack.pop_front();
            chk("ack_onehot", 256'(req_ack), 256'(a));
          end
          ack_cyc = cyc;
        end
        if (hmac_start) chk("start_latency", 256'(cyc), 256'(ack_cyc + 1));
        if (rsp_valid != 4'b0000) begin
          if (sb_rsp.size() == 0) begin
            chk("rsp_unexpected", 256'(rsp_valid), 256'h0);
          end else begin
            e = sb_rsp.pop_front();
            chk("rsp_valid", 256'(rsp_valid), 256'(e.onehot));
            chk("rsp_error", 256'(rsp_error), 256'(e.err));
            chk("rsp_tag", rsp_tag, e.tag);
            exp_cyc = e.err ? (start_cyc + 1 + TMO) : (done_cyc + 1);
            chk("rsp_latency", 256'(cyc), 256'(exp_cyc));
          end
          zchk_cyc = cyc + 2;
        end
        if (cyc == zchk_cyc) chk("zeroize", dut.r_key_q | dut.r_msg_q | dut.r_tag_q, 256'h0);
      end
    end
  end

  task automatic expect_op(input logic [1:0] idx, input logic err);
    rsp_t e;
    e.onehot = 4'b0001 << idx;
    e.err    = err;
    e.tag    = err ? 256'h0 : f_tag(keys[idx], msgs[idx]);
    sb_ack.push_back(e.onehot);
    sb_rsp.push_back(e);
  endtask

  task automatic wait_ack(input logic [1:0] idx);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ack[idx] && n < 200);
    if (!req_ack[idx]) bound_fail("ack_wait");
    @(posedge clock);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb_rsp.size() != 0 || arb_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) bound_fail("idle_wait");
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [1:0] idx, input int delay, input logic err);
    eng_delay = delay;
    expect_op(idx, err);
    req_valid[idx] = 1'b1;
    wait_ack(idx);
    wait_idle(2000);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n_acks;
    int n;
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      keys[i] = {32{8'hA0 + 8'(i)}};
      msgs[i] = {32{8'h30 + 8'(i)}};
    end
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 256'({req_ack, rsp_valid, rsp_error, arb_busy, hmac_start}), 256'h0);
    chk("reset_buses", rsp_tag | hmac_key | hmac_message, 256'h0);
    chk("reset_regs", dut.r_key_q | dut.r_msg_q | dut.r_tag_q, 256'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fairness: all four held for eight operations.
    eng_delay = 5;
    for (int k = 0; k < 8; k++) expect_op(2'(k % 4), 1'b0);
    req_valid = 4'b1111;
    n_acks = 0;
    n = 0;
    while (n_acks < 8 && n < 500) begin
      @(negedge clock);
      n++;
      if (req_ack != 4'b0000) n_acks++;
    end
    if (n_acks < 8) bound_fail("fairness_acks");
    @(posedge clock);
    #1 req_valid = '0;
    wait_idle(500);

    // Single request: 0x0B key, "Hi There" message, 150-cycle engine.
    keys[2] = {32{8'h0B}};
    msgs[2] = {64'h4869_2054_6865_7265, 192'h0};
    do_req(2'd2, 150, 1'b0);

    // Timeout, then a normal request, then done exactly on the timeout cycle, then one late.
    do_req(2'd1, 0, 1'b1);
    do_req(2'd3, 10, 1'b0);
    do_req(2'd0, TMO, 1'b0);
    do_req(2'd2, TMO + 1, 1'b1);

    // Reset during WAIT aborts without a response and resets the pointer.
    eng_delay = 200;
    sb_ack.push_back(4'b1000);
    req_valid[3] = 1'b1;
    wait_ack(2'd3);
    repeat (50) @(posedge clock);
    #2;
    chk("busy_in_wait", 256'(arb_busy), 256'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", 256'({req_ack, rsp_valid, rsp_error, arb_busy, hmac_start}), 256'h0);
    chk("abort_buses", rsp_tag | hmac_key | hmac_message, 256'h0);
    chk("abort_regs", dut.r_key_q | dut.r_msg_q | dut.r_tag_q, 256'h0);
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    eng_delay = 5;
    expect_op(2'd0, 1'b0);
    expect_op(2'd1, 1'b0);
    req_valid = 4'b0011;
    wait_ack(2'd0);
    wait_ack(2'd1);
    wait_idle(500);

    repeat (5) @(posedge clock);
    chk("sb_rsp_left", 256'(sb_rsp.size()), 256'h0);
    chk("sb_ack_left", 256'(sb_ack.size()), 256'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
